// File: rtl/seq_gen_sar_if.sv
// Handshake/bus bundle for seq_gen_sar: burst control in, serial frame and status out.
interface seq_gen_sar_if;
   logic       start;
   logic [3:0] rep_cnt;
   logic       abort;
   logic       seq_out;
   logic       seq_valid;
   logic       busy;
   logic       done;
   logic [3:0] seq_num;

   modport master (
      output start, rep_cnt, abort,
      input  seq_out, seq_valid, busy, done, seq_num
   );

   modport slave (
      input  start, rep_cnt, abort,
      output seq_out, seq_valid, busy, done, seq_num
   );
endinterface

// File: rtl/seq_gen_sar.sv
// Burst serial frame generator: sends PATTERN MSB-first rep_cnt times, then pulses done.
// Define SEQ_GEN_GUARD_EN to insert one guard bit (GAP state) between frames of a burst.
module seq_gen_sar #(
   parameter logic [4:0] PATTERN = 5'b11011
) (
   input  logic          clk,
   input  logic          reset,
   seq_gen_sar_if.slave  bus
);

`ifdef SEQ_GEN_GUARD_EN
   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

   state_t     state_q;
   logic [2:0] idx_q;
   logic [3:0] rep_q;
   logic [3:0] frm_cnt_q;
   logic [3:0] seq_num_q;
   logic       seq_out_q;
   logic       seq_valid_q;
   logic       busy_q;
   logic       done_q;

   logic [3:0] seq_num_d;
   logic [3:0] frm_cnt_d;
   logic [3:0] rep_d;
   logic       last_frame;

   always_comb begin
      seq_num_d  = (seq_num_q == 4'd9) ? 4'd0 : seq_num_q + 4'd1;
      frm_cnt_d  = frm_cnt_q + 4'd1;
      last_frame = (frm_cnt_d == rep_q);
      rep_d      = (bus.rep_cnt == 4'd0) ? 4'd1 : bus.rep_cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= 3'd4;
         rep_q       <= 4'd0;
         frm_cnt_q   <= 4'd0;
         seq_num_q   <= 4'd0;
         seq_out_q   <= 1'b0;
         seq_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               seq_out_q   <= 1'b0;
               seq_valid_q <= 1'b0;
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               idx_q       <= 3'd4;
               frm_cnt_q   <= 4'd0;
               // abort has priority over start while idle
               if (bus.start && !bus.abort) begin
                  state_q     <= SHIFT;
                  rep_q       <= rep_d;
                  seq_out_q   <= PATTERN[4];
                  seq_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end

            SHIFT: begin
               if (bus.abort) begin
                  state_q     <= IDLE;
                  seq_out_q   <= 1'b0;
                  seq_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  idx_q       <= 3'd4;
                  frm_cnt_q   <= 4'd0;
               end else if (idx_q != 3'd0) begin
                  idx_q     <= idx_q - 3'd1;
                  seq_out_q <= PATTERN[idx_q - 3'd1];
               end else begin
                  seq_num_q <= seq_num_d;
                  frm_cnt_q <= frm_cnt_d;
                  idx_q     <= 3'd4;
                  if (last_frame) begin
                     state_q     <= DONE;
                     seq_out_q   <= 1'b0;
                     seq_valid_q <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
`ifdef SEQ_GEN_GUARD_EN
                     state_q     <= GAP;
                     seq_out_q   <= 1'b0;
                     seq_valid_q <= 1'b1;
`else
                     state_q     <= SHIFT;
                     seq_out_q   <= PATTERN[4];
                     seq_valid_q <= 1'b1;
`endif
                  end
               end
            end

`ifdef SEQ_GEN_GUARD_EN
            GAP: begin
               if (bus.abort) begin
                  state_q     <= IDLE;
                  seq_out_q   <= 1'b0;
                  seq_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  frm_cnt_q   <= 4'd0;
               end else begin
                  state_q     <= SHIFT;
                  seq_out_q   <= PATTERN[4];
                  seq_valid_q <= 1'b1;
               end
               idx_q <= 3'd4;
            end
`endif

            DONE: begin
               state_q     <= IDLE;
               seq_out_q   <= 1'b0;
               seq_valid_q <= 1'b0;
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               idx_q       <= 3'd4;
               frm_cnt_q   <= 4'd0;
            end

            default: begin
               state_q     <= IDLE;
               seq_out_q   <= 1'b0;
               seq_valid_q <= 1'b0;
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               idx_q       <= 3'd4;
               frm_cnt_q   <= 4'd0;
            end
         endcase
      end
   end

   assign bus.seq_out   = seq_out_q;
   assign bus.seq_valid = seq_valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.seq_num   = seq_num_q;

endmodule

// File: doc/seq_gen_sar.md
SEQ_GEN_SAR -- requirements
Module: seq_gen_sar

Interface
REQ-001 Parameter PATTERN, default 5'b11011, is the serial frame, transmitted MSB first.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a burst; sampled only in IDLE.
REQ-005 rep_cnt  input  4  frames per burst; captured when start is accepted.
REQ-006 abort  input  1  terminates any burst in progress.
REQ-007 seq_out  output  1  registered serial data bit.
REQ-008 seq_valid  output  1  high when seq_out carries a transmitted bit.
REQ-009 busy  output  1  high from start acceptance until return to IDLE.
REQ-010 done  output  1  one-cycle pulse after the last bit of a completed burst.
REQ-011 seq_num  output  4  completed-frame counter, modulo 10.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, GAP and DONE.
REQ-013 IDLE: start=1 and abort=0 at an edge -> SHIFT, seq_out=PATTERN[4], seq_valid=1, busy=1 after that edge (one-cycle latency).
REQ-014 SHIFT: each edge SHALL present the next lower PATTERN bit; a 3-bit index counts 4 down to 0.
REQ-015 The edge leaving index 0 SHALL complete a frame and increment seq_num, with 9 wrapping to 0.
REQ-016 rep_cnt=0 SHALL be treated as 1; the captured count is immune to later rep_cnt changes.
REQ-017 Frames remaining after a frame completes -> next frame's PATTERN[4] (or GAP, REQ-026) on the next edge, no idle cycle.
REQ-018 Last frame complete -> DONE: seq_valid=0, seq_out=0, done=1 for exactly one cycle, busy=1.
REQ-019 DONE -> IDLE unconditionally on the next edge: done=0, busy=0.
REQ-020 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-021 abort=1 in SHIFT, GAP or DONE -> IDLE at the next edge, seq_valid=0, seq_out=0, busy=0.
REQ-022 On abort, done SHALL NOT pulse and an incomplete frame SHALL NOT increment seq_num.
REQ-023 start and abort both high in IDLE: abort wins; the block stays in IDLE.
REQ-024 In IDLE: seq_out=0, seq_valid=0, done=0.

Reset
REQ-025 reset=1 at an edge -> IDLE, seq_out=0, seq_valid=0, busy=0, done=0, seq_num=0, index=4, frame count=0, regardless of state or other inputs (including mid-burst).

Configuration
REQ-026 With macro SEQ_GEN_GUARD_EN defined, one guard bit (seq_out=0, seq_valid=1) SHALL be inserted between consecutive frames of a burst (state GAP), never after the last frame.
REQ-027 Without SEQ_GEN_GUARD_EN, GAP SHALL be absent and frames SHALL be strictly back-to-back.

Verification
REQ-028 reset, start pulse with rep_cnt=1 -> seq_out 1,1,0,1,1 with seq_valid=1 over 5 cycles, then done=1 for 1 cycle, seq_num=1, then busy=0.
REQ-029 rep_cnt=2, guard off -> 10 valid bits 1101111011; guard on -> 11 valid bits 11011011011; done once; seq_num +2.
REQ-030 12 single-frame bursts from reset -> seq_num reads 1..9, 0, 1, 2.
REQ-031 abort asserted on the 3rd bit of a rep_cnt=3 burst -> IDLE next edge, no done, seq_num unchanged.
REQ-032 start re-pulsed mid-burst, and start with abort in IDLE -> no extra frames, no state change.
REQ-033 reset asserted mid-frame with seq_num=5 -> all outputs 0 after the edge, seq_num=0.
